// File: rtl/branch_flag_ctrl.sv
// rtl/branch_flag_ctrl.sv - NZCV flag register and ID-stage branch resolution sequencer
// Owns architectural NZCV, resolves B.cond / CBZ / CBNZ, and sequences ID stall and IF flush.
module branch_flag_ctrl #(
  parameter logic FORWARD      = 1'b1,
  parameter int   FLUSH_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pipe_hold,
  input  logic       ex_valid,
  input  logic       ex_setflags,
  input  logic [3:0] ex_nzcv,
  input  logic       id_valid,
  input  logic       id_is_bcond,
  input  logic [3:0] id_cond,
  input  logic       id_is_cbz,
  input  logic       id_cbz_inv,
  input  logic       id_reg_zero,
  output logic [3:0] nzcv_q,
  output logic       br_taken,
  output logic       stall_id,
  output logic       flush_if,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;
  logic [3:0] held_cond, held_cond_next;
  logic       ex_flags_valid;
  logic [3:0] eff_nzcv;
  logic       taken;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: res = z;
      4'b0001: res = !z;
      4'b0010: res = c;
      4'b0011: res = !c;
      4'b0100: res = n;
      4'b0101: res = !n;
      4'b0110: res = v;
      4'b0111: res = !v;
      4'b1000: res = c & !z;
      4'b1001: res = !(c & !z);
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = !z & (n == v);
      4'b1101: res = !(!z & (n == v));
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  assign ex_flags_valid = ex_valid & ex_setflags;
  assign eff_nzcv       = (FORWARD && ex_flags_valid) ? ex_nzcv : nzcv_q;
  assign busy           = (state != IDLE);
  assign br_taken       = taken;

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    held_cond_next = held_cond;
    taken          = 1'b0;
    stall_id       = 1'b0;
    if (reset_n && !pipe_hold) begin
      case (state)
        IDLE: begin
          if (id_valid && id_is_bcond && ex_flags_valid && !FORWARD) begin
            stall_id       = 1'b1;
            state_next     = WAIT;
            held_cond_next = id_cond;
          end else if (id_valid && (id_is_bcond || id_is_cbz)) begin
            taken = id_is_bcond ? cond_pass(id_cond, eff_nzcv) : (id_reg_zero ^ id_cbz_inv);
            if (taken) begin
              state_next = FLUSH;
              cnt_next   = FLUSH_LOAD;
            end
          end
        end
        // nzcv_q here is the value captured on the WAIT entry edge
        WAIT: begin
          taken = cond_pass(held_cond, nzcv_q);
          if (taken) begin
            state_next = FLUSH;
            cnt_next   = FLUSH_LOAD;
          end else begin
            state_next = IDLE;
          end
        end
        FLUSH: begin
          cnt_next = cnt - 2'd1;
          if (cnt == 2'd1) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      held_cond <= 4'd0;
      flush_if  <= 1'b0;
      nzcv_q    <= 4'd0;
    end else if (!pipe_hold) begin
      state     <= state_next;
      cnt       <= cnt_next;
      held_cond <= held_cond_next;
      flush_if  <= (state_next == FLUSH);
      if (ex_flags_valid) nzcv_q <= ex_nzcv;
    end
  end

endmodule
